cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

- Shares the single Common Data Bus (CDB) between the functional-unit result producers: ALU reservation stations, branch comparator, load buffer and store-ack path.
- Each producer hands its result into a one-deep holding slot.
- The arbiter picks one full slot per cycle and drives the registered CDB that feeds the ROB (CDB_ROBEN / CDB_ROBEN_Write_Data / CDB_Branch_Decision) and the RS forwarding logic.
- It also enforces ROB flush by discarding all in-flight results.

## Interface
Parameters:
- NUM_REQ, 4, number of producers (≥2)
- ROBEN_W, 5, ROB entry number width; value 0 means "no broadcast"
- DATA_W, 32, result width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- FU_valid  in  NUM_REQ  producer i offers a result
- FU_ready  out  NUM_REQ  producer i's slot accepts this cycle
- FU_ROBEN  in  NUM_REQ*ROBEN_W  target ROB entry, packed, producer i at [i*ROBEN_W +: ROBEN_W]
- FU_Write_Data  in  NUM_REQ*DATA_W  result value, packed likewise
- FU_Branch_Decision  in  NUM_REQ  taken flag (branches only, else 0)
- FLUSH_Flag  in  1  ROB mispredict flush
- CDB_ROBEN  out  ROBEN_W  broadcast entry, 0 = idle
- CDB_Write_Data  out  DATA_W  broadcast value
- CDB_Branch_Decision  out  1  broadcast taken flag
- CDB_Source  out  $clog2(NUM_REQ)  index of granted producer
- Pending  out  NUM_REQ  slot-full vector

## Operation
- Slot i loads {ROBEN, data, decision} when FU_valid[i] && FU_ready[i] && FU_ROBEN_i != 0.
- FU_valid with ROBEN 0 is accepted (ready high) and dropped; the slot is not loaded.
- FU_ready[i] = (~Pending[i] | grant[i]) & ~FLUSH_Flag & rst.
  - A slot granted this cycle reloads at the same edge: no bubble.
- Grant: exactly one full slot per cycle when any is full. The granted slot clears at the edge unless it reloads.
- The output register loads the granted slot each edge.
  - With no grant: CDB_ROBEN loads 0. CDB_Write_Data, CDB_Branch_Decision and CDB_Source hold their previous values.
- Flush: while FLUSH_Flag=1:
  - all slots clear at the edge;
  - no grant;
  - CDB_ROBEN loads 0;
  - incoming offers are refused.
- Round-robin pointer p is described under Configuration.

## Timing
- Reset values:
  - CDB_ROBEN, CDB_Write_Data, CDB_Branch_Decision, CDB_Source, Pending and p all 0.
  - FU_ready = 0 while rst low, all 1 the first cycle after release.
- Latency: accepted at edge N, then broadcast on the CDB from edge N+1 for one cycle, if granted.
- Throughput: 1 broadcast/cycle.
- Worst-case wait (round-robin): NUM_REQ-1 cycles after the slot fills.
- Each broadcast lasts exactly one cycle; consumers must sample it then.
- FLUSH_Flag and a grant in the same cycle: flush wins; nothing is broadcast the next cycle.
- Reset mid-operation: immediate clear of all state and outputs; pending results are lost.

## Configuration
- CDB_RR_ARB_EN defined: round-robin arbitration.
  - Grant the first full slot at index ≥ p, searching cyclically.
  - After a grant, p = granted+1, wrapping NUM_REQ-1 → 0.
  - p is unchanged on idle or flush cycles.
- CDB_RR_ARB_EN undefined: fixed priority, lowest index wins. No pointer register; producer 0 can starve others.

## Structure
- Shared package cdb_pkg holds:
  - default widths ROBEN_W/DATA_W/NUM_REQ;
  - producer index constants REQ_ALU=0, REQ_BRANCH=1, REQ_LOAD=2, REQ_STORE=3;
  - CDB_IDLE_ROBEN=0.
- One sub-module, cdb_rr_picker: combinational picker taking the request vector and start pointer, returning a one-hot grant and the encoded index.
  - Fixed-priority build ties the pointer to 0.

## Test plan
- Reset then single offer: FU_valid[0]=1, ROBEN=1, data=123 for one cycle. CDB_ROBEN=1, CDB_Write_Data=123, CDB_Source=0 for exactly one cycle after next edge, then CDB_ROBEN=0.
- Contention, round-robin: all four slots loaded in the same cycle with ROBEN 1..4 and data 10,20,30,40. Broadcasts appear on 4 consecutive cycles in order ROBEN 1,2,3,4, then p=0. In the fixed-priority build the order is also 1..4.
- Fairness / wrap: producer 0 offers every cycle (ROBEN 5), producer 3 offers once (ROBEN 9) while p=3. ROBEN 9 is broadcast before the next ROBEN 5 (round-robin). Fixed priority: 9 waits while 0 stays full.
- Back-to-back reload: producer 1 offers ROBEN 2 then ROBEN 3 on consecutive cycles with no other traffic. FU_ready[1] stays 1 and the CDB shows 2 then 3 with no idle gap.
- Branch plus flush: producer 1 offers ROBEN 4 with decision 1 and is broadcast with CDB_Branch_Decision=1. Next, slots 0 and 2 are loaded, then FLUSH_Flag pulses one cycle. Pending goes 0, CDB_ROBEN=0, and nothing from those slots is broadcast afterwards.
- Async reset mid-traffic: drop rst mid-cycle with 3 slots pending. Outputs and Pending go 0 immediately without a clock edge, and FU_ready=0 until rst rises.

Source files
------------

// File: rtl/cdb_pkg.sv
// ---------------------------------------------------------------------------
// cdb_pkg
// Shared constants for the Common Data Bus arbiter slice.
//   DEF_NUM_REQ / DEF_ROBEN_W / DEF_DATA_W : default producer count and widths
//   REQ_ALU / REQ_BRANCH / REQ_LOAD / REQ_STORE : producer index assignment
//   CDB_IDLE_ROBEN : ROB entry number that means "nothing on the bus"
// ---------------------------------------------------------------------------
package cdb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ROBEN_W = 5;
   localparam int DEF_DATA_W  = 32;

   localparam int REQ_ALU    = 0;
   localparam int REQ_BRANCH = 1;
   localparam int REQ_LOAD   = 2;
   localparam int REQ_STORE  = 3;

   localparam int CDB_IDLE_ROBEN = 0;

endpackage

// File: rtl/cdb_rr_picker.sv
// ---------------------------------------------------------------------------
// cdb_rr_picker
// Combinational cyclic picker: grants the first requesting index at or after
// the start pointer, wrapping around. A pointer tied to 0 gives plain
// lowest-index-wins priority.
// Ports:
//   req     in  NUM_REQ  request vector (full slots)
//   ptr     in  IDX_W    start index of the search
//   gnt     out NUM_REQ  one-hot grant, all zero when nothing requests
//   gnt_idx out IDX_W    encoded index of the grant (0 when none)
//   gnt_any out 1        a grant was issued
// ---------------------------------------------------------------------------
module cdb_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_any
);

   int ptr_i;

   // Two passes instead of a modulo index: first the upper segment
   // [ptr, NUM_REQ-1], then the wrapped segment [0, ptr-1].
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      ptr_i   = int'(ptr);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req[i] && (i >= ptr_i)) begin
            gnt_any = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req[i] && (i < ptr_i)) begin
            gnt_any = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single registered Common Data Bus between the result producers
// (ALU stations, branch comparator, load buffer, store-ack). Every producer
// owns a one-deep holding slot; one full slot is broadcast per cycle. A ROB
// flush empties all slots and suppresses the broadcast.
//
// Build option: define CDB_RR_ARB_EN for round-robin arbitration; without it
// the lowest-index full slot always wins and no pointer register exists.
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous reset, active low
//   FU_valid            in   producer i offers a result
//   FU_ready            out  producer i's slot accepts this cycle
//   FU_ROBEN            in   target ROB entry per producer (packed)
//   FU_Write_Data       in   result value per producer (packed)
//   FU_Branch_Decision  in   branch taken flag per producer
//   FLUSH_Flag          in   ROB mispredict flush
//   CDB_ROBEN           out  broadcast ROB entry, 0 = idle
//   CDB_Write_Data      out  broadcast value
//   CDB_Branch_Decision out  broadcast taken flag
//   CDB_Source          out  index of the producer being broadcast
//   Pending             out  slot-full vector
// ---------------------------------------------------------------------------
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ROBEN_W = DEF_ROBEN_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           FU_valid,
   output logic [NUM_REQ-1:0]           FU_ready,
   input  logic [NUM_REQ*ROBEN_W-1:0]   FU_ROBEN,
   input  logic [NUM_REQ*DATA_W-1:0]    FU_Write_Data,
   input  logic [NUM_REQ-1:0]           FU_Branch_Decision,
   input  logic                         FLUSH_Flag,
   output logic [ROBEN_W-1:0]           CDB_ROBEN,
   output logic [DATA_W-1:0]            CDB_Write_Data,
   output logic                         CDB_Branch_Decision,
   output logic [$clog2(NUM_REQ)-1:0]   CDB_Source,
   output logic [NUM_REQ-1:0]           Pending
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] vld_p0;
   logic [ROBEN_W-1:0] roben_p0 [NUM_REQ];
   logic [DATA_W-1:0]  data_p0  [NUM_REQ];
   logic [NUM_REQ-1:0] br_p0;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic [IDX_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] load;

   logic [ROBEN_W-1:0] sel_roben;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_br;

   // Flush masks the requests so that no slot is granted while it is high.
   assign req = vld_p0 & {NUM_REQ{~FLUSH_Flag}};

`ifdef CDB_RR_ARB_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rr_ptr <= '0;
      else if (gnt_any)
         rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   end
`else
   assign rr_ptr = '0;
`endif

   cdb_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // A granted slot empties at this edge, so it may take a new result in the
   // same cycle without a bubble.
   assign FU_ready = (~vld_p0 | gnt) & {NUM_REQ{~FLUSH_Flag & rst}};

   // Offers addressed to ROB entry 0 are handshaken but never stored.
   always_comb begin
      load = '0;
      for (int i = 0; i < NUM_REQ; i++)
         load[i] = FU_valid[i] & FU_ready[i] &
                   (FU_ROBEN[i*ROBEN_W +: ROBEN_W] != ROBEN_W'(CDB_IDLE_ROBEN));
   end

   // ---- stage p0: holding slots ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0 <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (FLUSH_Flag)
               vld_p0[i] <= 1'b0;
            else if (load[i])
               vld_p0[i] <= 1'b1;
            else if (gnt[i])
               vld_p0[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (load[i]) begin
            roben_p0[i] <= FU_ROBEN[i*ROBEN_W +: ROBEN_W];
            data_p0[i]  <= FU_Write_Data[i*DATA_W +: DATA_W];
            br_p0[i]    <= FU_Branch_Decision[i];
         end
      end
   end

   assign Pending = vld_p0;

   // Grant is one-hot, so an AND-OR mux selects the winning slot.
   always_comb begin
      sel_roben = '0;
      sel_data  = '0;
      sel_br    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_roben = sel_roben | roben_p0[i];
            sel_data  = sel_data  | data_p0[i];
            sel_br    = sel_br    | br_p0[i];
         end
      end
   end

   // ---- stage p1: registered CDB ----
   // Only the ROB tag returns to idle; value, flag and source keep their
   // last broadcast contents between grants.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         CDB_ROBEN           <= '0;
         CDB_Write_Data      <= '0;
         CDB_Branch_Decision <= 1'b0;
         CDB_Source          <= '0;
      end else if (gnt_any) begin
         CDB_ROBEN           <= sel_roben;
         CDB_Write_Data      <= sel_data;
         CDB_Branch_Decision <= sel_br;
         CDB_Source          <= gnt_idx;
      end else begin
         CDB_ROBEN           <= ROBEN_W'(CDB_IDLE_ROBEN);
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter with a slot-level reference model and a
// per-cycle comparison, plus literal expectations for each scenario.
// Honours CDB_RR_ARB_EN to pick round-robin or fixed-priority expectations.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int N  = 4;
   localparam int RW = 5;
   localparam int DW = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    FU_valid;
   logic [N-1:0]    FU_ready;
   logic [N*RW-1:0] FU_ROBEN;
   logic [N*DW-1:0] FU_Write_Data;
   logic [N-1:0]    FU_Branch_Decision;
   logic            FLUSH_Flag;
   logic [RW-1:0]   CDB_ROBEN;
   logic [DW-1:0]   CDB_Write_Data;
   logic            CDB_Branch_Decision;
   logic [IW-1:0]   CDB_Source;
   logic [N-1:0]    Pending;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(N), .ROBEN_W(RW), .DATA_W(DW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .FU_valid            (FU_valid),
      .FU_ready            (FU_ready),
      .FU_ROBEN            (FU_ROBEN),
      .FU_Write_Data       (FU_Write_Data),
      .FU_Branch_Decision  (FU_Branch_Decision),
      .FLUSH_Flag          (FLUSH_Flag),
      .CDB_ROBEN           (CDB_ROBEN),
      .CDB_Write_Data      (CDB_Write_Data),
      .CDB_Branch_Decision (CDB_Branch_Decision),
      .CDB_Source          (CDB_Source),
      .Pending             (Pending)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Each slot is a one-entry holder; the bus picks the first full slot
   // counting cyclically from the pointer (pointer stays 0 for fixed priority).
   bit [N-1:0]  m_full = '0;
   bit [RW-1:0] m_roben [N];
   bit [DW-1:0] m_data  [N];
   bit [N-1:0]  m_br    = '0;
   int          m_ptr   = 0;
   bit [RW-1:0] e_roben = '0;
   bit [DW-1:0] e_data  = '0;
   bit          e_br    = 1'b0;
   int          e_src   = 0;
   int          m_w;

   function automatic int winner(input bit [N-1:0] full, input int ptr, input bit flush);
      if (flush) return -1;
      for (int k = 0; k < N; k++) begin
         if (full[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_full  <= '0;
         m_ptr   <= 0;
         e_roben <= '0;
         e_data  <= '0;
         e_br    <= 1'b0;
         e_src   <= 0;
      end else begin
         m_w = winner(m_full, m_ptr, FLUSH_Flag);
         if (m_w >= 0) begin
            e_roben <= m_roben[m_w];
            e_data  <= m_data[m_w];
            e_br    <= m_br[m_w];
            e_src   <= m_w;
`ifdef CDB_RR_ARB_EN
            m_ptr   <= (m_w + 1) % N;
`endif
         end else begin
            e_roben <= '0;
         end
         for (int i = 0; i < N; i++) begin
            if (FLUSH_Flag)
               m_full[i] <= 1'b0;
            else if (FU_valid[i] && (!m_full[i] || i == m_w) && FU_ROBEN[i*RW +: RW] != 0) begin
               m_full[i]  <= 1'b1;
               m_roben[i] <= FU_ROBEN[i*RW +: RW];
               m_data[i]  <= FU_Write_Data[i*DW +: DW];
               m_br[i]    <= FU_Branch_Decision[i];
            end else if (i == m_w)
               m_full[i] <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int          c_w;
   bit [N-1:0]  c_rdy;
   always @(negedge clk) begin
      c_w = rst ? winner(m_full, m_ptr, FLUSH_Flag) : -1;
      for (int i = 0; i < N; i++)
         c_rdy[i] = rst && !FLUSH_Flag && (!m_full[i] || i == c_w);
      chk("m_cdb_roben", 32'(CDB_ROBEN), 32'(e_roben));
      chk("m_cdb_data",  CDB_Write_Data, e_data);
      chk("m_cdb_br",    32'(CDB_Branch_Decision), 32'(e_br));
      chk("m_cdb_src",   32'(CDB_Source), e_src);
      chk("m_pending",   32'(Pending), 32'(m_full));
      chk("m_ready",     32'(FU_ready), 32'(c_rdy));
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      FU_valid           = '0;
      FU_ROBEN           = '0;
      FU_Write_Data      = '0;
      FU_Branch_Decision = '0;
      FLUSH_Flag         = 1'b0;
   endtask

   task automatic offer(input int i, input int rb, input int d, input bit br);
      FU_valid[i]               = 1'b1;
      FU_ROBEN[i*RW +: RW]      = RW'(rb);
      FU_Write_Data[i*DW +: DW] = DW'(d);
      FU_Branch_Decision[i]     = br;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
   endtask

`ifdef CDB_RR_ARB_EN
   int fair_exp [5] = '{9, 5, 5, 5, 0};
`else
   int fair_exp [5] = '{5, 5, 5, 5, 9};
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      idle_in();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_roben",   32'(CDB_ROBEN), 0);
      chk("rst_pending", 32'(Pending), 0);
      chk("rst_ready",   32'(FU_ready), 0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rel_ready", 32'(FU_ready), 32'hF);

      // single offer
      offer(REQ_ALU, 1, 123, 1'b0);
      tick();
      idle_in();
      chk("single_pending", 32'(Pending), 32'h1);
      tick();
      chk("single_roben", 32'(CDB_ROBEN), 1);
      chk("single_data",  CDB_Write_Data, 123);
      chk("single_src",   32'(CDB_Source), 0);
      tick();
      chk("single_idle",  32'(CDB_ROBEN), 0);
      chk("single_hold",  CDB_Write_Data, 123);

      // contention from a freshly reset pointer
      do_reset();
      offer(REQ_ALU,    1, 10, 1'b0);
      offer(REQ_BRANCH, 2, 20, 1'b0);
      offer(REQ_LOAD,   3, 30, 1'b0);
      offer(REQ_STORE,  4, 40, 1'b0);
      tick();
      idle_in();
      chk("cont_pending", 32'(Pending), 32'hF);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("cont_roben", 32'(CDB_ROBEN), 32'(k + 1));
         chk("cont_data",  CDB_Write_Data, 32'(10 * (k + 1)));
         chk("cont_src",   32'(CDB_Source), 32'(k));
      end
      tick();
      chk("cont_idle", 32'(CDB_ROBEN), 0);

      // fairness / wrap: slot 2 grant moves the pointer to 3
      offer(REQ_LOAD, 7, 70, 1'b0);
      tick();
      idle_in();
      offer(REQ_ALU,   5, 50, 1'b0);
      offer(REQ_STORE, 9, 90, 1'b0);
      tick();
      FU_valid[REQ_STORE] = 1'b0;
      chk("fair_first", 32'(CDB_ROBEN), 7);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 2) idle_in();
         chk("fair_seq", 32'(CDB_ROBEN), 32'(fair_exp[k]));
      end
      tick();
      chk("fair_drained", 32'(Pending), 0);

      // back-to-back reload on producer 1
      offer(REQ_BRANCH, 2, 200, 1'b0);
      #1 chk("b2b_ready0", 32'(FU_ready[REQ_BRANCH]), 1);
      tick();
      offer(REQ_BRANCH, 3, 300, 1'b0);
      #1 chk("b2b_ready1", 32'(FU_ready[REQ_BRANCH]), 1);
      tick();
      idle_in();
      chk("b2b_roben0", 32'(CDB_ROBEN), 2);
      chk("b2b_data0",  CDB_Write_Data, 200);
      tick();
      chk("b2b_roben1", 32'(CDB_ROBEN), 3);
      chk("b2b_data1",  CDB_Write_Data, 300);
      tick();
      chk("b2b_idle",   32'(CDB_ROBEN), 0);

      // branch broadcast, then flush of freshly loaded slots
      offer(REQ_BRANCH, 4, 44, 1'b1);
      tick();
      idle_in();
      tick();
      chk("br_roben", 32'(CDB_ROBEN), 4);
      chk("br_flag",  32'(CDB_Branch_Decision), 1);
      offer(REQ_ALU,  6, 60, 1'b0);
      offer(REQ_LOAD, 8, 80, 1'b0);
      tick();
      idle_in();
      FLUSH_Flag = 1'b1;
      offer(REQ_STORE, 10, 100, 1'b0);
      #1;
      chk("fl_pending_before", 32'(Pending), 32'h5);
      chk("fl_ready",          32'(FU_ready), 0);
      tick();
      idle_in();
      chk("fl_pending_after", 32'(Pending), 0);
      chk("fl_roben",         32'(CDB_ROBEN), 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("fl_quiet", 32'(CDB_ROBEN), 0);
      end

      // asynchronous reset with three slots pending
      offer(REQ_ALU,    11, 110, 1'b0);
      offer(REQ_BRANCH, 12, 120, 1'b0);
      offer(REQ_LOAD,   13, 130, 1'b1);
      tick();
      idle_in();
      chk("ar_pending", 32'(Pending), 32'h7);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("ar_roben",   32'(CDB_ROBEN), 0);
      chk("ar_data",    CDB_Write_Data, 0);
      chk("ar_br",      32'(CDB_Branch_Decision), 0);
      chk("ar_src",     32'(CDB_Source), 0);
      chk("ar_pending", 32'(Pending), 0);
      chk("ar_ready",   32'(FU_ready), 0);
      tick();
      tick();
      chk("ar_ready_held", 32'(FU_ready), 0);
      rst = 1'b1;
      #1;
      chk("ar_ready_rel", 32'(FU_ready), 32'hF);
      tick();
      chk("ar_lost", 32'(CDB_ROBEN), 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
